// File: rtl/x25519_ladder_sequencer.sv
// ---------------------------------------------------------------------------
// x25519_ladder_sequencer
//
// Drives the Montgomery ladder for one X25519 scalar multiplication. The
// scalar is clamped and the projective pairs are seeded from the base
// u-coordinate. One iteration per scalar bit (MSB first) is issued to the
// downstream iteration stage, and each iteration's results are fed back as
// the next operands. The final xzm pair is presented with a one-cycle done.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          one-cycle run request, honoured only when idle
//   scalar_in      raw little-endian scalar k (sampled with start)
//   base_x         base u-coordinate (sampled with start, bit 255 masked)
//   busy           high from the cycle after an accepted start through done
//   done           one-cycle pulse, xzm_result valid from this cycle
//   xzm_result     final {Z, X} of xzm
//   iter_en        one-cycle issue strobe to the iteration stage
//   iter_xzm1      {Z, X} operand for x(m+1)
//   iter_xzm       {Z, X} operand for x(m)
//   iter_work_low  {8'h00, masked base_x}
//   iter_b         clamped scalar bit for the current iteration
//   iter_out_valid result strobe from the iteration stage
//   iter_xzm_out   new xzm from the iteration stage
//   iter_xzm1_out  new xzm1 from the iteration stage
// ---------------------------------------------------------------------------
module x25519_ladder_sequencer #(
  parameter int NUM_BITS = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] scalar_in,
  input  logic [255:0] base_x,
  output logic         busy,
  output logic         done,
  output logic [511:0] xzm_result,
  output logic         iter_en,
  output logic [511:0] iter_xzm1,
  output logic [511:0] iter_xzm,
  output logic [263:0] iter_work_low,
  output logic         iter_b,
  input  logic         iter_out_valid,
  input  logic [511:0] iter_xzm_out,
  input  logic [511:0] iter_xzm1_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_t;

  // Clamping clears bits 2:0 and 255 and forces bit 254.
  localparam logic [255:0] LP_CLAMP_AND = {1'b0, {252{1'b1}}, 3'b000};
  localparam logic [255:0] LP_CLAMP_OR  = {2'b01, 254'd0};
  localparam logic [255:0] LP_BASE_MASK = {1'b0, {255{1'b1}}};
  localparam logic [7:0]   LP_TOP_IDX   = 8'(NUM_BITS - 1);

  state_t       r_state;
  state_t       w_nextState;
  logic [255:0] r_scalarQ;
  logic [7:0]   r_bitIdx;
  logic [511:0] r_xzm;
  logic [511:0] r_xzm1;
  logic [263:0] r_workLow;
  logic         r_iterB;
  logic [511:0] r_result;

  logic [255:0] w_clamped;
  logic [255:0] w_baseMasked;
  logic         w_startAccept;
  logic         w_capture;
  logic         w_lastBit;
  logic [7:0]   w_nextIdx;
  logic         w_busy;
  logic         w_done;
  logic         w_iterEn;

  assign w_clamped    = (scalar_in & LP_CLAMP_AND) | LP_CLAMP_OR;
  assign w_baseMasked = base_x & LP_BASE_MASK;
  assign w_lastBit    = (r_bitIdx == 8'd0);
  assign w_nextIdx    = r_bitIdx - 8'd1;

  // Next-state and strobe decode. A result strobe only counts in WAIT; in
  // any other state it is a protocol error and is dropped.
  always_comb begin
    w_nextState   = r_state;
    w_startAccept = 1'b0;
    w_capture     = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_iterEn      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_startAccept = 1'b1;
          w_nextState   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_busy      = 1'b1;
        w_iterEn    = 1'b1;
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (iter_out_valid) begin
          w_capture   = 1'b1;
          w_nextState = w_lastBit ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Ladder datapath. The operand registers double as the xzm/xzm1 ladder
  // state; they are only reloaded when the next ISSUE is known to follow,
  // so they stay stable from one ISSUE to the next. The last result goes
  // straight into xzm_result. The zero check on bit_idx precedes the
  // decrement, so the index never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scalarQ <= '0;
      r_bitIdx  <= '0;
      r_xzm     <= '0;
      r_xzm1    <= '0;
      r_workLow <= '0;
      r_iterB   <= 1'b0;
      r_result  <= '0;
    end else if (w_startAccept) begin
      r_scalarQ <= w_clamped;
      r_bitIdx  <= LP_TOP_IDX;
      r_xzm     <= {256'd0, 256'd1};
      r_xzm1    <= {256'd1, w_baseMasked};
      r_workLow <= {8'h00, w_baseMasked};
      r_iterB   <= w_clamped[NUM_BITS-1];
      r_result  <= '0;
    end else if (w_capture && !w_lastBit) begin
      r_bitIdx  <= w_nextIdx;
      r_xzm     <= iter_xzm_out;
      r_xzm1    <= iter_xzm1_out;
      r_iterB   <= r_scalarQ[w_nextIdx];
    end else if (w_capture) begin
      r_result  <= iter_xzm_out;
    end
  end

  assign busy          = w_busy;
  assign done          = w_done;
  assign iter_en       = w_iterEn;
  assign xzm_result    = r_result;
  assign iter_xzm      = r_xzm;
  assign iter_xzm1     = r_xzm1;
  assign iter_work_low = r_workLow;
  assign iter_b        = r_iterB;

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// ---------------------------------------------------------------------------
// tb_x25519_ladder_sequencer
//
// Two sequencer instances: a 4-bit ladder driven by an iteration model with
// latency 3 (xzm+1, xzm1+2), and a full 255-bit ladder driven by an echoing
// model with latency 1 for seeding and clamping.
// ---------------------------------------------------------------------------
module tb_x25519_ladder_sequencer;

  localparam logic [255:0] BASE_U =
    256'h8123456789abcdef_0011223344556677_8899aabbccddeeff_fedcba98765473c6;
  localparam logic [255:0] BASE_U_MASKED =
    256'h0123456789abcdef_0011223344556677_8899aabbccddeeff_fedcba98765473c6;
  localparam logic [511:0] GARBAGE = {16{32'hdeadbeef}};

  logic         clk = 1'b0;
  logic         rst;
  logic         start4;
  logic         start255;
  logic [255:0] scalarIn;
  logic [255:0] baseX;

  logic         vld4;
  logic [511:0] xo4;
  logic [511:0] x1o4;
  logic         busy4;
  logic         done4;
  logic [511:0] res4;
  logic         en4;
  logic [511:0] xzm14;
  logic [511:0] xzm4;
  logic [263:0] wl4;
  logic         b4;

  logic         vld255;
  logic [511:0] xo255;
  logic [511:0] x1o255;
  logic         busy255;
  logic         done255;
  logic [511:0] res255;
  logic         en255;
  logic [511:0] xzm1255;
  logic [511:0] xzm255;
  logic [263:0] wl255;
  logic         b255;

  int nVectors     = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  x25519_ladder_sequencer #(.NUM_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .scalar_in(scalarIn), .base_x(baseX),
    .busy(busy4), .done(done4), .xzm_result(res4), .iter_en(en4),
    .iter_xzm1(xzm14), .iter_xzm(xzm4), .iter_work_low(wl4), .iter_b(b4),
    .iter_out_valid(vld4), .iter_xzm_out(xo4), .iter_xzm1_out(x1o4)
  );

  x25519_ladder_sequencer #(.NUM_BITS(255)) dut255 (
    .clk(clk), .rst(rst), .start(start255), .scalar_in(scalarIn), .base_x(baseX),
    .busy(busy255), .done(done255), .xzm_result(res255), .iter_en(en255),
    .iter_xzm1(xzm1255), .iter_xzm(xzm255), .iter_work_low(wl255), .iter_b(b255),
    .iter_out_valid(vld255), .iter_xzm_out(xo255), .iter_xzm1_out(x1o255)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the 4-bit ladder with a latency-3 iteration model. Optional
  // disturbances: a start pulse, a stray result strobe, or an early return.
  task automatic run4(input int disturbCyc, input int strayCyc, input int stopCyc,
                      output int doneCyc, output logic [511:0] res,
                      output logic [263:0] wlAtDone, output int issues,
                      output int busyFall, output logic busyEnAt1);
    int due;
    logic pend;
    logic [511:0] latX;
    logic [511:0] latX1;
    pend = 1'b0; due = -1; latX = '0; latX1 = '0;
    doneCyc = -1; busyFall = -1; issues = 0; res = '0; wlAtDone = '0; busyEnAt1 = 1'b0;
    start4 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start4 = 1'b0;
      vld4 = 1'b0;
      xo4 = '0;
      x1o4 = '0;
      if (c == stopCyc) return;
      if (c == 1) busyEnAt1 = busy4 & en4;
      if (pend && c == due) begin
        vld4 = 1'b1;
        xo4  = latX + 512'd1;
        x1o4 = latX1 + 512'd2;
        pend = 1'b0;
      end
      if (c == strayCyc) begin
        vld4 = 1'b1;
        xo4  = GARBAGE;
        x1o4 = GARBAGE;
      end
      if (c == disturbCyc) begin
        start4   = 1'b1;
        scalarIn = '0;
        baseX    = 256'h1234;
      end
      if (en4) begin
        issues++;
        pend  = 1'b1;
        due   = c + 3;
        latX  = xzm4;
        latX1 = xzm14;
      end
      if (done4 && doneCyc < 0) begin
        doneCyc  = c;
        res      = res4;
        wlAtDone = wl4;
      end
      if (doneCyc >= 0 && !busy4) begin
        busyFall = c;
        break;
      end
    end
    start4 = 1'b0;
    vld4 = 1'b0;
  endtask

  // Runs the 255-bit ladder with an echoing latency-1 model, recording the
  // iter_b sequence indexed by bit position and the first ISSUE operands.
  task automatic run255(output logic [254:0] bitsSeen, output logic firstB,
                        output logic [511:0] firstXzm, output logic [511:0] firstXzm1,
                        output logic [263:0] firstWl, output int issues,
                        output int doneCyc);
    int due;
    logic pend;
    logic [511:0] latX;
    logic [511:0] latX1;
    pend = 1'b0; due = -1; latX = '0; latX1 = '0;
    bitsSeen = '0; firstB = 1'b0; firstXzm = '0; firstXzm1 = '0; firstWl = '0;
    issues = 0; doneCyc = -1;
    start255 = 1'b1;
    for (int c = 1; c <= 700; c++) begin
      tick();
      start255 = 1'b0;
      vld255 = 1'b0;
      xo255 = '0;
      x1o255 = '0;
      if (pend && c == due) begin
        vld255 = 1'b1;
        xo255  = latX;
        x1o255 = latX1;
        pend   = 1'b0;
      end
      if (en255) begin
        if (issues == 0) begin
          firstB    = b255;
          firstXzm  = xzm255;
          firstXzm1 = xzm1255;
          firstWl   = wl255;
        end
        if (issues < 255) bitsSeen[254 - issues] = b255;
        issues++;
        pend  = 1'b1;
        due   = c + 1;
        latX  = xzm255;
        latX1 = xzm1255;
      end
      if (done255) begin
        doneCyc = c;
        break;
      end
    end
    vld255 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (busy4 !== 1'b0) begin $display("[TB] FAIL reset_busy: got %b want 0", busy4); nMiscompares++; end
    nVectors++;
    if (done4 !== 1'b0) begin $display("[TB] FAIL reset_done: got %b want 0", done4); nMiscompares++; end
    nVectors++;
    if (en4 !== 1'b0) begin $display("[TB] FAIL reset_iter_en: got %b want 0", en4); nMiscompares++; end
    nVectors++;
    if (b4 !== 1'b0) begin $display("[TB] FAIL reset_iter_b: got %b want 0", b4); nMiscompares++; end
    nVectors++;
    if (res4 !== 512'd0) begin $display("[TB] FAIL reset_result: got %h want 0", res4); nMiscompares++; end
    nVectors++;
    if (xzm4 !== 512'd0) begin $display("[TB] FAIL reset_iter_xzm: got %h want 0", xzm4); nMiscompares++; end
    nVectors++;
    if (xzm14 !== 512'd0) begin $display("[TB] FAIL reset_iter_xzm1: got %h want 0", xzm14); nMiscompares++; end
    nVectors++;
    if (wl4 !== 264'd0) begin $display("[TB] FAIL reset_work_low: got %h want 0", wl4); nMiscompares++; end
    nVectors++;
    if (busy255 !== 1'b0) begin $display("[TB] FAIL reset_busy255: got %b want 0", busy255); nMiscompares++; end
    nVectors++;
    rst = 1'b0;
  endtask

  task automatic test_seeding();
    logic [254:0] bits;
    logic [254:0] expBits;
    logic fb;
    logic [511:0] fx;
    logic [511:0] fx1;
    logic [263:0] fwl;
    int issues;
    int doneCyc;
    scalarIn = '0;
    baseX = BASE_U;
    run255(bits, fb, fx, fx1, fwl, issues, doneCyc);
    expBits = '0;
    expBits[254] = 1'b1;
    if (fb !== 1'b1) begin $display("[TB] FAIL seed_iter_b: got %b want 1", fb); nMiscompares++; end
    nVectors++;
    if (fx !== {256'd0, 256'd1}) begin $display("[TB] FAIL seed_iter_xzm: got %h want %h", fx, {256'd0, 256'd1}); nMiscompares++; end
    nVectors++;
    if (fx1 !== {256'd1, BASE_U_MASKED}) begin $display("[TB] FAIL seed_iter_xzm1: got %h want %h", fx1, {256'd1, BASE_U_MASKED}); nMiscompares++; end
    nVectors++;
    if (fwl !== {8'h00, BASE_U_MASKED}) begin $display("[TB] FAIL seed_work_low: got %h want %h", fwl, {8'h00, BASE_U_MASKED}); nMiscompares++; end
    nVectors++;
    if (bits !== expBits) begin $display("[TB] FAIL seed_bit_seq: got %h want %h", bits, expBits); nMiscompares++; end
    nVectors++;
    if (issues != 255) begin $display("[TB] FAIL seed_issue_count: got %0d want 255", issues); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_clamp();
    logic [254:0] bits;
    logic [254:0] expBits;
    logic fb;
    logic [511:0] fx;
    logic [511:0] fx1;
    logic [263:0] fwl;
    int issues;
    int doneCyc;
    scalarIn = {256{1'b1}};
    baseX = BASE_U;
    run255(bits, fb, fx, fx1, fwl, issues, doneCyc);
    expBits = {{252{1'b1}}, 3'b000};
    if (bits !== expBits) begin $display("[TB] FAIL clamp_bit_seq: got %h want %h", bits, expBits); nMiscompares++; end
    nVectors++;
    if (issues != 255) begin $display("[TB] FAIL clamp_issue_count: got %0d want 255", issues); nMiscompares++; end
    nVectors++;
    if (doneCyc != 511) begin $display("[TB] FAIL clamp_done_cycle: got %0d want 511", doneCyc); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_feedback();
    int doneCyc;
    int issues;
    int busyFall;
    logic [511:0] res;
    logic [263:0] wl;
    logic be1;
    scalarIn = {256{1'b1}};
    baseX = BASE_U;
    run4(-1, -1, -1, doneCyc, res, wl, issues, busyFall, be1);
    if (be1 !== 1'b1) begin $display("[TB] FAIL fb_busy_en_cycle1: got %b want 1", be1); nMiscompares++; end
    nVectors++;
    if (doneCyc != 17) begin $display("[TB] FAIL fb_done_cycle: got %0d want 17", doneCyc); nMiscompares++; end
    nVectors++;
    if (res !== {256'd0, 256'd5}) begin $display("[TB] FAIL fb_result: got %h want %h", res, {256'd0, 256'd5}); nMiscompares++; end
    nVectors++;
    if (issues != 4) begin $display("[TB] FAIL fb_issue_count: got %0d want 4", issues); nMiscompares++; end
    nVectors++;
    if (busyFall != 18) begin $display("[TB] FAIL fb_busy_fall: got %0d want 18", busyFall); nMiscompares++; end
    nVectors++;
    if (wl !== {8'h00, BASE_U_MASKED}) begin $display("[TB] FAIL fb_work_low: got %h want %h", wl, {8'h00, BASE_U_MASKED}); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_stray();
    int doneCyc;
    int issues;
    int busyFall;
    logic [511:0] res;
    logic [263:0] wl;
    logic be1;
    // Stray strobe while idle, after a completed run whose last operand was {0,4}.
    vld4 = 1'b1;
    xo4  = GARBAGE;
    x1o4 = GARBAGE;
    tick();
    vld4 = 1'b0;
    tick();
    if (busy4 !== 1'b0) begin $display("[TB] FAIL stray_idle_busy: got %b want 0", busy4); nMiscompares++; end
    nVectors++;
    if (en4 !== 1'b0) begin $display("[TB] FAIL stray_idle_iter_en: got %b want 0", en4); nMiscompares++; end
    nVectors++;
    if (done4 !== 1'b0) begin $display("[TB] FAIL stray_idle_done: got %b want 0", done4); nMiscompares++; end
    nVectors++;
    if (xzm4 !== {256'd0, 256'd4}) begin $display("[TB] FAIL stray_idle_iter_xzm: got %h want %h", xzm4, {256'd0, 256'd4}); nMiscompares++; end
    nVectors++;
    // Stray strobe during the second ISSUE cycle.
    scalarIn = {256{1'b1}};
    baseX = BASE_U;
    run4(-1, 5, -1, doneCyc, res, wl, issues, busyFall, be1);
    if (doneCyc != 17) begin $display("[TB] FAIL stray_issue_done_cycle: got %0d want 17", doneCyc); nMiscompares++; end
    nVectors++;
    if (res !== {256'd0, 256'd5}) begin $display("[TB] FAIL stray_issue_result: got %h want %h", res, {256'd0, 256'd5}); nMiscompares++; end
    nVectors++;
    if (issues != 4) begin $display("[TB] FAIL stray_issue_count: got %0d want 4", issues); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_busy_start();
    int doneCyc;
    int issues;
    int busyFall;
    logic [511:0] res;
    logic [263:0] wl;
    logic be1;
    scalarIn = {256{1'b1}};
    baseX = BASE_U;
    run4(3, -1, -1, doneCyc, res, wl, issues, busyFall, be1);
    if (doneCyc != 17) begin $display("[TB] FAIL busy_start_done_cycle: got %0d want 17", doneCyc); nMiscompares++; end
    nVectors++;
    if (res !== {256'd0, 256'd5}) begin $display("[TB] FAIL busy_start_result: got %h want %h", res, {256'd0, 256'd5}); nMiscompares++; end
    nVectors++;
    if (wl !== {8'h00, BASE_U_MASKED}) begin $display("[TB] FAIL busy_start_work_low: got %h want %h", wl, {8'h00, BASE_U_MASKED}); nMiscompares++; end
    nVectors++;
    if (issues != 4) begin $display("[TB] FAIL busy_start_issue_count: got %0d want 4", issues); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_mid_reset();
    int doneCyc;
    int issues;
    int busyFall;
    logic [511:0] res;
    logic [263:0] wl;
    logic be1;
    scalarIn = {256{1'b1}};
    baseX = BASE_U;
    run4(-1, -1, 6, doneCyc, res, wl, issues, busyFall, be1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (busy4 !== 1'b0) begin $display("[TB] FAIL midrst_busy: got %b want 0", busy4); nMiscompares++; end
    nVectors++;
    if (en4 !== 1'b0) begin $display("[TB] FAIL midrst_iter_en: got %b want 0", en4); nMiscompares++; end
    nVectors++;
    if (done4 !== 1'b0) begin $display("[TB] FAIL midrst_done: got %b want 0", done4); nMiscompares++; end
    nVectors++;
    if (b4 !== 1'b0) begin $display("[TB] FAIL midrst_iter_b: got %b want 0", b4); nMiscompares++; end
    nVectors++;
    if (xzm4 !== 512'd0) begin $display("[TB] FAIL midrst_iter_xzm: got %h want 0", xzm4); nMiscompares++; end
    nVectors++;
    if (xzm14 !== 512'd0) begin $display("[TB] FAIL midrst_iter_xzm1: got %h want 0", xzm14); nMiscompares++; end
    nVectors++;
    if (wl4 !== 264'd0) begin $display("[TB] FAIL midrst_work_low: got %h want 0", wl4); nMiscompares++; end
    nVectors++;
    if (res4 !== 512'd0) begin $display("[TB] FAIL midrst_result: got %h want 0", res4); nMiscompares++; end
    nVectors++;
    run4(-1, -1, -1, doneCyc, res, wl, issues, busyFall, be1);
    if (doneCyc != 17) begin $display("[TB] FAIL midrst_rerun_done_cycle: got %0d want 17", doneCyc); nMiscompares++; end
    nVectors++;
    if (res !== {256'd0, 256'd5}) begin $display("[TB] FAIL midrst_rerun_result: got %h want %h", res, {256'd0, 256'd5}); nMiscompares++; end
    nVectors++;
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0;
    start255 = 1'b0;
    scalarIn = '0;
    baseX = '0;
    vld4 = 1'b0;
    xo4 = '0;
    x1o4 = '0;
    vld255 = 1'b0;
    xo255 = '0;
    x1o255 = '0;
    test_reset();
    tick();
    test_seeding();
    test_clamp();
    test_feedback();
    test_stray();
    tick();
    test_busy_start();
    tick();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/x25519_ladder_sequencer.md
# x25519_ladder_sequencer

Control stage directly upstream of `X25519_MainLoopIteration`. It runs the full Montgomery ladder for one X25519 scalar multiplication:
- clamps the scalar;
- seeds the projective (X:Z) pairs from the base u-coordinate;
- issues one iteration per scalar bit, MSB first, to the iteration stage;
- feeds each iteration's results back as the next operands;
- presents the final xzm pair to the downstream inversion/encode stage.

## Interface
Parameters:
- `NUM_BITS`, default 255: ladder iterations per run. The bit index runs from `NUM_BITS-1` down to 0. Legal range is 1..255; reduced values are for simulation only.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `scalar_in`  in  256  raw little-endian scalar k, sampled with `start`.
- `base_x`  in  256  base u-coordinate, sampled with `start`. Bit 255 is masked to 0.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the result is valid.
- `xzm_result`  out  512  final {Z[255:0], X[255:0]} of xzm. Holds until the next accepted `start` or `rst`.
- `iter_en`  out  1  one-cycle issue strobe to the iteration stage.
- `iter_xzm1`  out  512  {Z, X} operand for x(m+1).
- `iter_xzm`  out  512  {Z, X} operand for x(m).
- `iter_work_low`  out  264  {8'h00, base_x_masked}.
- `iter_b`  out  1  current clamped scalar bit.
- `iter_out_valid`  in  1  result strobe from the iteration stage.
- `iter_xzm_out`  in  512  new xzm from the iteration stage.
- `iter_xzm1_out`  in  512  new xzm1 from the iteration stage.

## Operation
- Clamping on `start` acceptance:
  - k_c = k with bits 2:0 cleared, bit 255 cleared, bit 254 set.
  - k_c is registered in `scalar_q`.
- Seeding on `start` acceptance:
  - xzm ← {256'd0, 256'd1}, i.e. (1:0).
  - xzm1 ← {256'd1, base_x_masked}, i.e. (u:1).
  - `bit_idx` ← `NUM_BITS-1`.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - `start` is accepted → ISSUE.
  - `iter_out_valid` is ignored.
- ISSUE:
  - `iter_en`=1 for exactly this cycle.
  - `iter_b` = `scalar_q[bit_idx]`.
  - Operands come from the xzm/xzm1 registers.
  - Next state is WAIT.
- WAIT:
  - On `iter_out_valid`, capture `iter_xzm_out` into xzm and `iter_xzm1_out` into xzm1.
  - If `bit_idx`==0 → FINISH.
  - Otherwise decrement `bit_idx` → ISSUE.
- FINISH:
  - `done`=1 and `xzm_result` ← xzm; valid from this cycle.
  - Next state is IDLE.
- Conditional swapping belongs to the iteration stage (driven by `iter_b`); this block never swaps.
- `iter_xzm`, `iter_xzm1`, `iter_work_low` and `iter_b` are registered and stable from ISSUE until the next ISSUE.
- `start` while `busy` is ignored; the run is not restarted.
- `iter_out_valid` in ISSUE or FINISH is a protocol error by the iteration stage. It is ignored, with no capture and no state change.
- `bit_idx` is 8 bits wide and never wraps: the 0 check precedes the decrement.

## Timing
- Reset values:
  - state=IDLE; `busy`=0, `done`=0, `iter_en`=0, `iter_b`=0.
  - `xzm_result`=0, `iter_xzm`=0, `iter_xzm1`=0, `iter_work_low`=0.
  - `scalar_q`=0, `bit_idx`=0.
- `rst` mid-run returns to IDLE on the next edge; all in-flight results are discarded.
- `start` accepted in cycle 0:
  - `busy`=1 and `iter_en`=1 in cycle 1.
- Let L = cycles from `iter_en` to `iter_out_valid`, with L ≥ 1.
  - Next `iter_en` occurs at L+1 cycles after the previous one.
- Last `iter_out_valid` in cycle t:
  - `done` and final `xzm_result` in cycle t+1.
  - `busy` falls in cycle t+2.
  - Earliest next `start` acceptance is cycle t+2.
- Total run length is `NUM_BITS`·(L+1)+1 cycles from `start` to `done`.

## Test plan
- Seeding: `scalar_in`=0, `base_x`=256'h...73c6 (test vector u), `NUM_BITS`=255 → first ISSUE has:
  - `iter_b`=1 (bit 254 forced by clamping);
  - `iter_xzm`={0,1};
  - `iter_xzm1`={1,u};
  - `iter_work_low`={8'h00,u}.
- Clamping: `scalar_in`=all ones → `iter_b` sequence is 1 for idx 254..3, then 0,0,0.
- Feedback: bench model with L=3 returning xzm_out=xzm_in+1, xzm1_out=xzm1_in+2, `NUM_BITS`=4 → `done` at cycle 17 with `xzm_result`={0,5}.
- Busy/start: pulse `start` during WAIT → no re-seed, same `done` cycle and result as the undisturbed run.
- Stray strobes:
  - `iter_out_valid` in IDLE → no state change.
  - `iter_out_valid` in ISSUE → no capture.
- Reset: assert `rst` at iteration 2 of 4 → next cycle all outputs are at reset values; a new `start` runs to a correct `done`.
